// File: rtl/bird_pkg.sv
// bird_pkg: shared definitions for the bird physics engine.
//   - FSM state encodings (3-bit constants)
//   - default draw / erase colours
//   - scan_cnt_w(): pixel-index counter width for a w x h sprite
package bird_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INIT_DRAW = 3'd1;
  localparam logic [2:0] ST_WAIT      = 3'd2;
  localparam logic [2:0] ST_UPDATE    = 3'd3;
  localparam logic [2:0] ST_ERASE     = 3'd4;
  localparam logic [2:0] ST_DRAW      = 3'd5;
  localparam logic [2:0] ST_DEAD      = 3'd6;

  localparam logic [2:0] BIRD_COLOUR_DEF = 3'b010;
  localparam logic [2:0] BG_COLOUR_DEF   = 3'b000;

  // Width of a counter indexing every pixel of a w x h sprite (at least 1).
  function automatic int scan_cnt_w(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

endpackage

// File: rtl/bird_sprite_scan.sv
// bird_sprite_scan: walks a BIRD_W x BIRD_H rectangle row-major and presents
// one pixel per accepted handshake. Reused for erase, draw and initial draw.
// Ports:
//   clk, reset        clock, async active-high reset
//   start             load base_x/base_y/colour and begin a new scan
//   base_x, base_y    top-left corner of the rectangle
//   colour            colour for every pixel of this scan
//   plot_ready        downstream accepts the presented pixel
//   plot_valid        pixel presented
//   plot_x/y/colour   presented pixel
//   done              combinational pulse: last pixel accepted this cycle
module bird_sprite_scan
  import bird_pkg::*;
#(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int BIRD_W = 4,
  parameter int BIRD_H = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [X_W-1:0] base_x,
  input  logic [Y_W-1:0] base_y,
  input  logic [2:0]     colour,
  input  logic           plot_ready,
  output logic           plot_valid,
  output logic [X_W-1:0] plot_x,
  output logic [Y_W-1:0] plot_y,
  output logic [2:0]     plot_colour,
  output logic           done
);

  localparam int CW   = scan_cnt_w(BIRD_W, BIRD_H);
  localparam int NPIX = BIRD_W * BIRD_H;

  logic [CW-1:0]  idx;
  logic [X_W-1:0] bx_r;
  logic [Y_W-1:0] by_r;
  logic [2:0]     col_r;
  logic           last;

  assign last = (idx == CW'(NPIX - 1));
  assign done = plot_valid && plot_ready && last;

  // Address derived from registered base + index, so it cannot move while
  // the pixel is stalled.
  assign plot_x      = bx_r + X_W'(int'(idx) % BIRD_W);
  assign plot_y      = by_r + Y_W'(int'(idx) / BIRD_W);
  assign plot_colour = col_r;

  // start has priority so a new scan can follow the previous one's last
  // pixel with no bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      plot_valid <= 1'b0;
      idx        <= '0;
      bx_r       <= '0;
      by_r       <= '0;
      col_r      <= '0;
    end else if (start) begin
      plot_valid <= 1'b1;
      idx        <= '0;
      bx_r       <= base_x;
      by_r       <= base_y;
      col_r      <= colour;
    end else if (plot_valid && plot_ready) begin
      if (last) plot_valid <= 1'b0;
      else      idx        <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/bird_physics_engine.sv
// bird_physics_engine: per-frame gravity/flap model for the bird sprite plus
// erase-then-draw pixel streaming to the VGA plotter (valid/ready).
// Ports:
//   clk, reset            clock, async active-high reset
//   start                 start/restart from IDLE or DEAD
//   flap                  debounced key level; rising edge requests an impulse
//   tick                  one-cycle frame strobe
//   plot_ready            plotter accepts pixel
//   plot_valid/x/y/colour pixel stream
//   bird_y, velocity      current sprite top row and signed velocity
//   busy                  high while erasing/drawing after an update
//   dead                  high in DEAD
//   tick_missed           pulse when a tick arrives while plotting
// Optional feature: define BIRD_CEIL_KILL_EN to make ceiling contact lethal.
module bird_physics_engine
  import bird_pkg::*;
#(
  parameter int         Y_W         = 7,
  parameter int         X_W         = 8,
  parameter int         V_W         = 5,
  parameter int         BIRD_X      = 20,
  parameter int         BIRD_W      = 4,
  parameter int         BIRD_H      = 4,
  parameter int         START_Y     = 30,
  parameter int         FLOOR_Y     = 120,
  parameter int         GRAVITY     = 1,
  parameter int         FLAP_V      = 4,
  parameter int         MAX_FALL    = 6,
  parameter logic [2:0] BIRD_COLOUR = BIRD_COLOUR_DEF,
  parameter logic [2:0] BG_COLOUR   = BG_COLOUR_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  flap,
  input  logic                  tick,
  input  logic                  plot_ready,
  output logic                  plot_valid,
  output logic [X_W-1:0]        plot_x,
  output logic [Y_W-1:0]        plot_y,
  output logic [2:0]            plot_colour,
  output logic [Y_W-1:0]        bird_y,
  output logic signed [V_W-1:0] velocity,
  output logic                  busy,
  output logic                  dead,
  output logic                  tick_missed
);

  localparam int SW = Y_W + 2;
  localparam logic signed [V_W:0]   GRAV_W = (V_W + 1)'(GRAVITY);
  localparam logic signed [V_W:0]   MAXF_W = (V_W + 1)'(MAX_FALL);
  localparam logic signed [V_W-1:0] FLAP_N = V_W'(-FLAP_V);
  localparam logic signed [SW-1:0]  Y_LIM  = SW'(FLOOR_Y - BIRD_H);

  logic [2:0]     state;
  logic [Y_W-1:0] old_y;
  logic           flap_q;
  logic           flap_pending;
  logic           death_pending;
  logic           flap_edge;

  // ---------------- physics step (used only in UPDATE) ----------------
  logic signed [V_W:0]   vel_g;
  logic signed [V_W-1:0] vel_n;
  logic signed [SW-1:0]  sum;
  logic [Y_W-1:0]        y_upd;
  logic signed [V_W-1:0] v_upd;
  logic                  die_upd;

  always_comb begin
    // one extra bit so vel+GRAVITY cannot wrap before the clamp
    vel_g = (V_W + 1)'(velocity) + GRAV_W;
    if (flap_pending)       vel_n = FLAP_N;
    else if (vel_g > MAXF_W) vel_n = V_W'(MAX_FALL);
    else                    vel_n = vel_g[V_W-1:0];

    sum     = $signed({2'b00, bird_y}) + SW'(vel_n);
    y_upd   = bird_y;
    v_upd   = vel_n;
    die_upd = 1'b0;
    if (sum < 0) begin
      y_upd = '0;
      v_upd = '0;
`ifdef BIRD_CEIL_KILL_EN
      die_upd = 1'b1;
`else
      die_upd = 1'b0;
`endif
    end else if (sum >= Y_LIM) begin
      y_upd   = Y_W'(FLOOR_Y - BIRD_H);
      v_upd   = '0;
      die_upd = 1'b1;
    end else begin
      y_upd = sum[Y_W-1:0];
    end
  end

  // ---------------- sprite scanner control ----------------
  logic           scan_start;
  logic           scan_done;
  logic [Y_W-1:0] scan_y;
  logic [2:0]     scan_colour;

  // Scans are kicked on the transition edge so plot_valid rises the cycle
  // after UPDATE and DRAW follows ERASE back-to-back.
  always_comb begin
    scan_start  = 1'b0;
    scan_y      = bird_y;
    scan_colour = BIRD_COLOUR;
    case (state)
      ST_IDLE, ST_DEAD: begin
        scan_start = start;
        scan_y     = Y_W'(START_Y);
      end
      ST_UPDATE: begin
        scan_start  = 1'b1;
        scan_y      = old_y;
        scan_colour = BG_COLOUR;
      end
      ST_ERASE: scan_start = scan_done;   // bird_y already holds the new row
      default: ;
    endcase
  end

  bird_sprite_scan #(
    .X_W    (X_W),
    .Y_W    (Y_W),
    .BIRD_W (BIRD_W),
    .BIRD_H (BIRD_H)
  ) u_scan (
    .clk         (clk),
    .reset       (reset),
    .start       (scan_start),
    .base_x      (X_W'(BIRD_X)),
    .base_y      (scan_y),
    .colour      (scan_colour),
    .plot_ready  (plot_ready),
    .plot_valid  (plot_valid),
    .plot_x      (plot_x),
    .plot_y      (plot_y),
    .plot_colour (plot_colour),
    .done        (scan_done)
  );

  // ---------------- FSM ----------------
  assign flap_edge = flap && !flap_q;
  assign busy      = (state == ST_ERASE) || (state == ST_DRAW);
  assign dead      = (state == ST_DEAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      bird_y        <= Y_W'(START_Y);
      velocity      <= '0;
      old_y         <= Y_W'(START_Y);
      flap_q        <= 1'b0;
      flap_pending  <= 1'b0;
      death_pending <= 1'b0;
      tick_missed   <= 1'b0;
    end else begin
      flap_q      <= flap;
      tick_missed <= tick && ((state == ST_INIT_DRAW) || (state == ST_ERASE) ||
                              (state == ST_DRAW));

      // A new edge in the UPDATE cycle survives for the next frame.
      if (state == ST_UPDATE || state == ST_IDLE || state == ST_DEAD)
        flap_pending <= 1'b0;
      if (flap_edge && state != ST_IDLE && state != ST_DEAD)
        flap_pending <= 1'b1;

      case (state)
        ST_IDLE, ST_DEAD: begin
          if (start) begin
            state         <= ST_INIT_DRAW;
            bird_y        <= Y_W'(START_Y);
            velocity      <= '0;
            death_pending <= 1'b0;
          end
        end
        ST_INIT_DRAW: if (scan_done) state <= ST_WAIT;
        ST_WAIT: begin
          if (tick) begin
            old_y <= bird_y;
            state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          bird_y        <= y_upd;
          velocity      <= v_upd;
          death_pending <= die_upd;
          state         <= ST_ERASE;
        end
        ST_ERASE: if (scan_done) state <= ST_DRAW;
        ST_DRAW:  if (scan_done) state <= death_pending ? ST_DEAD : ST_WAIT;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bird_physics_engine.md
Name: bird_physics_engine

Overview:
Parametrised successor to the single-speed bird controller. Runs a signed-velocity gravity/flap model once per frame tick, clamps the bird to the playfield and flags death on floor contact. After each update it streams an erase-then-draw pixel sequence for the BIRD_W x BIRD_H sprite to the VGA plotter over a valid/ready handshake. Sits between the frame-tick divider, the KEY-driven flap input and the VGA plot arbiter.

Parameters:
Y_W, 7, width of bird_y and plot_y (pixel rows)
X_W, 8, width of plot_x
V_W, 5, width of signed velocity (pixels/tick)
BIRD_X, 20, fixed left column of sprite
BIRD_W, 4, sprite width (pixels)
BIRD_H, 4, sprite height (pixels)
START_Y, 30, y loaded on reset/start
FLOOR_Y, 120, first row below playfield; bird dies when y+BIRD_H reaches it
GRAVITY, 1, velocity added per tick (unsigned)
FLAP_V, 4, upward speed on flap (velocity set to -FLAP_V)
MAX_FALL, 6, positive velocity clamp
BIRD_COLOUR, 3'b010, draw colour; BG_COLOUR, 3'b000, erase colour

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
start  in  1  level; begins/restarts game from IDLE or DEAD
flap  in  1  level (debounced key); only rising edge acts
tick  in  1  one-cycle frame strobe
plot_ready  in  1  plotter accepts pixel this cycle
plot_valid  out  1  pixel presented
plot_x  out  X_W  pixel column
plot_y  out  Y_W  pixel row
plot_colour  out  3  pixel colour
bird_y  out  Y_W  current top row of sprite
velocity  out  V_W  current signed velocity
busy  out  1  high in ERASE/DRAW
dead  out  1  high in DEAD
tick_missed  out  1  one-cycle pulse when tick arrives while busy

Behaviour:
- Reset (async): state IDLE, bird_y=START_Y, velocity=0, plot_valid=0, busy=0, dead=0, tick_missed=0, flap_pending=0, flap_q=0.
- States: IDLE, INIT_DRAW, WAIT, UPDATE, ERASE, DRAW, DEAD. Screen y grows downward.
- IDLE: start=1 -> INIT_DRAW (y=START_Y, vel=0). INIT_DRAW draws sprite at START_Y, then WAIT.
- Flap edge: flap_q registered each cycle; flap & ~flap_q sets flap_pending in any state except IDLE/DEAD. Holding flap produces one impulse. flap_pending cleared in UPDATE.
- WAIT: tick -> UPDATE (old_y latched = bird_y). Ticks in ERASE/DRAW/INIT_DRAW are dropped with tick_missed pulse.
- UPDATE (1 cycle): vel_n = flap_pending ? -FLAP_V : min(vel+GRAVITY, MAX_FALL); sum = bird_y + sign-extended vel_n computed at Y_W+2 bits signed. sum<0 -> y=0, vel=0. sum >= FLOOR_Y-BIRD_H -> y=FLOOR_Y-BIRD_H, vel=0, death flagged. Else y=sum, vel=vel_n. Next: ERASE.
- ERASE: BIRD_W*BIRD_H pixels row-major at (BIRD_X+col, old_y+row), BG_COLOUR. DRAW: same scan at new bird_y, BIRD_COLOUR. If y unchanged, ERASE still runs (simple, deterministic).
- Handshake: plot_x/y/colour stable while plot_valid && !plot_ready; counter advances only on valid&&ready; plot_valid may stay high back-to-back. Last pixel of ERASE accepted -> DRAW next cycle.
- After DRAW: death flagged -> DEAD, else WAIT. DEAD: dead=1, outputs frozen, flap/tick ignored; start -> INIT_DRAW (erase of old sprite not required).
- start ignored outside IDLE/DEAD.
- Latency: tick to first plot_valid = 2 cycles; full frame update = 2 + 2*BIRD_W*BIRD_H cycles at plot_ready=1.

Optional Feature:
BIRD_CEIL_KILL_EN: defined -> sum<0 clamps y=0 and also flags death (ceiling is lethal). Undefined -> ceiling clamps y=0, vel=0, no death.

Decomposition:
- bird_pkg: state enum, colour constants, sprite-scan counter width function (clog2 of BIRD_W*BIRD_H).
- Sub-module bird_sprite_scan: base x/y, colour, start, handshake in; plot outputs and done pulse out; reused for ERASE, DRAW, INIT_DRAW.

Test Plan:
- Reset then start, plot_ready=1 -> 16 pixels at x 20..23, y 30..33, colour 3'b010; state WAIT, bird_y=30.
- 3 ticks, no flap -> velocity 1,2,3; bird_y 31,33,36; each tick 16 erase + 16 draw pixels.
- Hold flap high across 5 ticks from y=36 -> exactly one impulse: velocity -4, y=32, then velocity -3, -2, ... .
- Free fall from y=100 -> velocity caps at 6; y clamps to 116, dead=1 after final DRAW; further ticks/flaps cause no plot_valid.
- plot_ready toggling 1-0-0-1 during DRAW -> plot_x/y held while stalled; tick during busy gives tick_missed pulse, no extra UPDATE.
- Flaps from y=2 -> y clamps 0, vel 0; with BIRD_CEIL_KILL_EN dead=1; assert reset mid-DRAW -> plot_valid=0, bird_y=30, IDLE immediately.
